uart_serial_tx: RTL and testbench

//  Transmit half of the memory-mapped UART. Serializes one byte per request onto tx_pin as an 8-bit LSB-first

---
 rtl/uart_serial_tx_pkg.sv | 31 +++
 rtl/uart_serial_tx_if.sv | 27 ++
 rtl/uart_serial_tx_baud_tick.sv | 41 ++++
 rtl/uart_serial_tx.sv | 192 +++++++++++++++++++
 tb/tb_uart_serial_tx.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/uart_serial_tx_pkg.sv
// Shared UART definitions: transmitter state encoding, line idle level and
// baud-rate helpers used by both the transmit and receive halves.
package uart_serial_tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic UART_IDLE_LEVEL = 1'b1;

    typedef struct packed {
        logic parity_en;
        logic parity_odd;
        logic two_stop;
    } frame_cfg_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int cnt_width(input int cpb);
        return (cpb > 2) ? $clog2(cpb) : 1;
    endfunction

    function automatic logic frame_parity(input logic [7:0] data, input logic odd);
        return odd ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_serial_tx_if.sv
// Request/status bundle between the CPU-side register block and the UART
// transmitter; master is the register side, slave is the transmitter.
interface uart_serial_tx_if;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_pin;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_pin,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_pin,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/uart_serial_tx_baud_tick.sv
// Bit-time counter: counts 0..CPB-1 while enabled, restarts at every bit
// boundary, and flags both the last clk of a bit and the clk before it.
module uart_baud_tick #(
    parameter int CPB = 434,
    parameter int CW  = 9
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o,
    output logic pre_tick_o
);

    localparam logic [CW-1:0] LAST = CW'(CPB - 1);
    localparam logic [CW-1:0] PRE  = CW'(CPB - 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o     = en_i && (cnt_q == LAST);
    assign pre_tick_o = en_i && (cnt_q == PRE);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_serial_tx.sv
// UART transmitter: synchronizes the CPU start request, then shifts one byte
// out LSB-first with optional parity and one or two stop bits.
//
//   state  | meaning
//   IDLE   | line high, waiting for a start edge
//   START  | driving the start bit (low)
//   DATA   | driving data bits 0..7 from the shift register
//   PARITY | driving the latched parity bit
//   STOP   | line high for 1 or 2 bit-times, done on the final clk
module uart_serial_tx
    import uart_serial_tx_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_serial_tx_if.slave bus
);

    localparam int         CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int         CW  = cnt_width(CPB);
    localparam frame_cfg_t CFG = '{
        parity_en:  (PARITY_EN != 0),
        parity_odd: (PARITY_ODD != 0),
        two_stop:   (STOP_BITS == 2)
    };

    logic       sync_meta_q;
    logic       sync_q;
    logic       sync_qq;
    logic [1:0] fill_q;
    logic       armed_q;

    logic [2:0] state_q,    state_d;
    logic [7:0] shift_q,    shift_d;
    logic [2:0] bit_idx_q,  bit_idx_d;
    logic       stop_idx_q, stop_idx_d;
    logic       parity_q,   parity_d;
    logic       pin_q,      pin_d;
    logic       busy_q,     busy_d;
    logic       done_q,     done_d;

    logic tick;
    logic pre_tick;
    logic start_edge;
    logic accept;
    logic last_stop;

    // A level already high when reset releases must not count as an edge:
    // the detector only arms after the synchronized request has been seen low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
            sync_qq     <= 1'b0;
            fill_q      <= 2'b00;
            armed_q     <= 1'b0;
        end else begin
            sync_meta_q <= bus.tx_start;
            sync_q      <= sync_meta_q;
            sync_qq     <= sync_q;
            fill_q      <= {fill_q[0], 1'b1};
            armed_q     <= armed_q | (fill_q[1] & ~sync_q);
        end
    end

    assign start_edge = sync_q & ~sync_qq & armed_q;
    assign accept     = start_edge && (state_q == ST_IDLE);
    assign last_stop  = (stop_idx_q == CFG.two_stop);

    uart_baud_tick #(
        .CPB (CPB),
        .CW  (CW)
    ) u_baud_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_i      (accept),
        .en_i       (busy_q),
        .tick_o     (tick),
        .pre_tick_o (pre_tick)
    );

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        parity_d   = parity_q;
        pin_d      = pin_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                pin_d = UART_IDLE_LEVEL;
                if (accept) begin
                    state_d    = ST_START;
                    shift_d    = bus.tx_data;
                    parity_d   = frame_parity(bus.tx_data, CFG.parity_odd);
                    bit_idx_d  = 3'd0;
                    stop_idx_d = 1'b0;
                    busy_d     = 1'b1;
                    pin_d      = ~UART_IDLE_LEVEL;
                end
            end

            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    pin_d   = shift_q[0];
                end
            end

            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == 3'd7) begin
                        if (CFG.parity_en) begin
                            state_d = ST_PARITY;
                            pin_d   = parity_q;
                        end else begin
                            state_d = ST_STOP;
                            pin_d   = UART_IDLE_LEVEL;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        pin_d     = shift_q[1];
                    end
                end
            end

            ST_PARITY: begin
                if (tick) begin
                    state_d = ST_STOP;
                    pin_d   = UART_IDLE_LEVEL;
                end
            end

            ST_STOP: begin
                pin_d  = UART_IDLE_LEVEL;
                // Registered done must be high during the last clk, so it is
                // armed one clk early.
                done_d = last_stop && pre_tick;
                if (tick) begin
                    if (last_stop) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                pin_d   = UART_IDLE_LEVEL;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shift_q    <= 8'h00;
            bit_idx_q  <= 3'd0;
            stop_idx_q <= 1'b0;
            parity_q   <= 1'b0;
            pin_q      <= UART_IDLE_LEVEL;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            parity_q   <= parity_d;
            pin_q      <= pin_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.tx_pin  = pin_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_serial_tx.sv
// Directed bench for uart_serial_tx: four instances cover 8N1, 8E1, 8O1 at
// 434 clks/bit and 8N2 at 4 clks/bit.
module tb_uart_serial_tx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] start_s;
    logic [7:0] data_s [4];
    logic [3:0] pin_s;
    logic [3:0] busy_s;
    logic [3:0] done_s;

    int n_chk  = 0;
    int n_fail = 0;
    int done_cnt [4];
    int low_cnt  [4];
    int hi_run3  = 0;
    int gap3     = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_serial_tx_if u_if ();

        uart_serial_tx #(
            .CLK_FREQ   ((g == 3) ? 16 : 50_000_000),
            .BAUD       ((g == 3) ? 4 : 115200),
            .PARITY_EN  ((g == 1 || g == 2) ? 1 : 0),
            .PARITY_ODD ((g == 2) ? 1 : 0),
            .STOP_BITS  ((g == 3) ? 2 : 1)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (u_if)
        );

        assign u_if.tx_start = start_s[g];
        assign u_if.tx_data  = data_s[g];
        assign pin_s[g]      = u_if.tx_pin;
        assign busy_s[g]     = u_if.tx_busy;
        assign done_s[g]     = u_if.tx_done;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (done_s[i] === 1'b1) done_cnt[i]++;
            if (pin_s[i] === 1'b0) low_cnt[i]++;
        end
        if (pin_s[3] === 1'b1) begin
            hi_run3++;
        end else begin
            if (hi_run3 > 0) gap3 = hi_run3;
            hi_run3 = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Starts a frame on instance d from a negedge and checks it clk by clk.
    // poke1/poke2 re-raise tx_start (with pdata) at those frame clks.
    task automatic send_frame(input int d, input logic [7:0] b, input int cpb,
                              input int nbits, input bit pen, input logic exp_par,
                              input int poke1, input int poke2, input logic [7:0] pdata);
        logic exp_bits [12];
        int   n, k, dn, dpos;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
        for (int i = 9; i < 12; i++) exp_bits[i] = 1'b1;
        if (pen) exp_bits[9] = exp_par;
        n    = cpb * nbits;
        dn   = 0;
        dpos = 0;
        data_s[d]  = b;
        start_s[d] = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk($sformatf("d%0d_%0h_lat_hi", d, b), pin_s[d], 1);
        @(posedge clk); @(negedge clk);
        for (int c = 1; c <= n; c++) begin
            k = (c - 1) / cpb;
            if (((c - 1) % cpb == 0) || ((c - 1) % cpb == cpb - 1))
                chk($sformatf("d%0d_%0h_bit%0d_clk%0d", d, b, k, c), pin_s[d], exp_bits[k]);
            if (done_s[d] === 1'b1) begin
                dn++;
                dpos = c;
            end
            if (c == 1 || c == n)
                chk($sformatf("d%0d_%0h_busy_clk%0d", d, b, c), busy_s[d], 1);
            if (c == 2 || c == poke1 + 4) start_s[d] = 1'b0;
            if (c == poke1 || c == poke2) begin
                data_s[d]  = pdata;
                start_s[d] = 1'b1;
            end
            if (c < n) begin
                @(posedge clk); @(negedge clk);
            end
        end
        chk($sformatf("d%0d_%0h_done_count", d, b), dn, 1);
        chk($sformatf("d%0d_%0h_done_pos", d, b), dpos, n);
        @(posedge clk); @(negedge clk);
        chk($sformatf("d%0d_%0h_busy_after", d, b), busy_s[d], 0);
        chk($sformatf("d%0d_%0h_done_after", d, b), done_s[d], 0);
        chk($sformatf("d%0d_%0h_pin_after", d, b), pin_s[d], 1);
        start_s[d] = 1'b0;
    endtask

    initial begin
        int l0, d0;
        for (int i = 0; i < 4; i++) begin
            data_s[i]   = 8'h00;
            done_cnt[i] = 0;
            low_cnt[i]  = 0;
        end
        start_s = 4'hF;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;

        // Reset held with the request level high
        repeat (3) @(negedge clk);
        chk("rst_pin0", pin_s[0], 1);
        chk("rst_busy0", busy_s[0], 0);
        chk("rst_done0", done_s[0], 0);
        chk("rst_pin3", pin_s[3], 1);
        l0 = low_cnt[0];
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("rel_no_frame_low", low_cnt[0], l0);
        chk("rel_no_frame_busy", busy_s, 4'h0);
        start_s = 4'h0;
        repeat (5) @(negedge clk);

        // 8N1 0xA5
        send_frame(0, 8'hA5, 434, 10, 1'b0, 1'b0, 0, 0, 8'h00);
        repeat (10) @(negedge clk);

        // Edges mid-frame and in the done cycle are dropped
        send_frame(0, 8'hA5, 434, 10, 1'b0, 1'b0, 2000, 4338, 8'h3C);
        l0 = low_cnt[0];
        repeat (6) @(negedge clk);
        chk("drop_no_low", low_cnt[0], l0);
        chk("drop_busy", busy_s[0], 0);
        send_frame(0, 8'h3C, 434, 10, 1'b0, 1'b0, 0, 0, 8'h00);
        repeat (5) @(negedge clk);

        // Reset during data bit 4
        data_s[0]  = 8'h00;
        start_s[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rmid_start_low", pin_s[0], 0);
        start_s[0] = 1'b0;
        repeat (2200) @(negedge clk);
        chk("rmid_pre_pin", pin_s[0], 0);
        chk("rmid_pre_busy", busy_s[0], 1);
        d0 = done_cnt[0];
        #2 rst_n = 1'b0;
        #1;
        chk("rmid_async_pin", pin_s[0], 1);
        chk("rmid_async_busy", busy_s[0], 0);
        chk("rmid_async_done", done_s[0], 0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (2500) @(negedge clk);
        chk("rmid_no_done", done_cnt[0], d0);
        chk("rmid_idle_busy", busy_s[0], 0);
        send_frame(0, 8'h5A, 434, 10, 1'b0, 1'b0, 0, 0, 8'h00);

        // Parity: 0x07 has three ones
        send_frame(1, 8'h07, 434, 11, 1'b1, 1'b1, 0, 0, 8'h00);
        send_frame(2, 8'h07, 434, 11, 1'b1, 1'b0, 0, 0, 8'h00);

        // Two stop bits, 4 clks/bit, back-to-back
        send_frame(3, 8'h00, 4, 11, 1'b0, 1'b0, 0, 0, 8'h00);
        send_frame(3, 8'hFF, 4, 11, 1'b0, 1'b0, 0, 0, 8'h00);
        chk("stop2_gap", gap3, 11);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
